// File: rtl/tinyalu_param.sv
// Small multi-cycle ALU: single-cycle add/and/xor, multi-cycle multiply,
// with a start/done handshake and an illegal-opcode error pulse.
module tinyalu_param #(
    parameter int WIDTH      = 8,
    parameter int MUL_CYCLES = 3
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic [2:0]           op,
    input  logic                 start,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result,
    output logic                 busy,
    output logic                 err
);
    localparam int RW = 2 * WIDTH;
    localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;

    typedef enum logic [1:0] {IDLE, EXEC, MUL} state_t;

    state_t             state_q, state_d;
    logic               armed_q, armed_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [2:0]         op_q, op_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [RW-1:0]      result_q, result_d;
    logic               done_q, done_d;
    logic               ill_q, ill_d;
    logic               err_q, err_d;

    logic               capture;
    logic [RW-1:0]      a_ext, b_ext, exec_res;

    always_comb begin
        a_ext = RW'(a_q);
        b_ext = RW'(b_q);
        case (op_q)
            OP_AND:  exec_res = a_ext & b_ext;
            OP_XOR:  exec_res = a_ext ^ b_ext;
            default: exec_res = a_ext + b_ext;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        armed_d  = armed_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        done_d   = 1'b0;
        ill_d    = 1'b0;
        // illegal opcode is flagged at capture, reported one edge later
        err_d    = ill_q;
        capture  = (state_q == IDLE) && start && armed_q;

        if (!start) armed_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (capture) begin
                    armed_d = 1'b0;
                    a_d     = A;
                    b_d     = B;
                    op_d    = op;
                    case (op)
                        OP_NOP: ;
                        OP_ADD, OP_AND, OP_XOR: state_d = EXEC;
                        OP_MUL: begin
                            state_d = MUL;
                            cnt_d   = CW'(MUL_CYCLES - 1);
                        end
                        default: ill_d = 1'b1;
                    endcase
                end
            end
            EXEC: begin
                result_d = exec_res;
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            MUL: begin
                if (cnt_q == '0) begin
                    result_d = a_ext * b_ext;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            armed_q  <= 1'b1;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= OP_NOP;
            cnt_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            ill_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            armed_q  <= armed_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            done_q   <= done_d;
            ill_q    <= ill_d;
            err_q    <= err_d;
        end
    end

    assign done   = done_q;
    assign err    = err_q;
    assign result = result_q;
    assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_tinyalu_param.sv
// Bench for tinyalu_param: an 8-bit/3-cycle-mul instance and a
// 16-bit/1-cycle-mul instance checked against an arithmetic reference model.
module tb_tinyalu_param;
    logic        clk = 1'b0;
    logic        reset_n;

    logic [7:0]  a8, b8;
    logic [2:0]  op8;
    logic        start8, done8, busy8, err8;
    logic [15:0] result8;

    logic [15:0] a16, b16;
    logic [2:0]  op16;
    logic        start16, done16, busy16, err16;
    logic [31:0] result16;

    int n_tests = 0;
    int n_fail  = 0;
    longint exp8  = 0;
    longint exp16 = 0;
    bit cur_sel = 1'b0;

    always #5 clk = ~clk;

    tinyalu_param #(.WIDTH(8), .MUL_CYCLES(3)) dut8 (
        .clk(clk), .reset_n(reset_n), .A(a8), .B(b8), .op(op8), .start(start8),
        .done(done8), .result(result8), .busy(busy8), .err(err8)
    );

    tinyalu_param #(.WIDTH(16), .MUL_CYCLES(1)) dut16 (
        .clk(clk), .reset_n(reset_n), .A(a16), .B(b16), .op(op16), .start(start16),
        .done(done16), .result(result16), .busy(busy16), .err(err16)
    );

    wire        done_s   = cur_sel ? done16 : done8;
    wire        busy_s   = cur_sel ? busy16 : busy8;
    wire        err_s    = cur_sel ? err16  : err8;
    wire [31:0] result_s = cur_sel ? result16 : {16'h0, result8};

    task automatic check(input string tag, input longint got, input longint want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    function automatic longint ref_res(input int o, input longint a, input longint b);
        case (o)
            1:       return a + b;
            2:       return a & b;
            3:       return a ^ b;
            4:       return a * b;
            default: return 0;
        endcase
    endfunction

    task automatic drive(input bit sel, input logic [2:0] o, input longint a,
                         input longint b, input logic s);
        if (sel) begin
            a16 = a[15:0]; b16 = b[15:0]; op16 = o; start16 = s;
        end else begin
            a8 = a[7:0]; b8 = b[7:0]; op8 = o; start8 = s;
        end
    endtask

    // issue one command, hold start for 'hold' cycles after capture, then check
    task automatic cmd(input bit sel, input logic [2:0] o, input longint a,
                       input longint b, input int hold);
        int     w      = sel ? 16 : 8;
        int     mc     = sel ? 1 : 3;
        longint mask   = (longint'(1) << w) - 1;
        longint am     = a & mask;
        longint bm     = b & mask;
        bit     legal  = (o >= 3'd1) && (o <= 3'd4);
        bit     illeg  = (o >= 3'd5);
        int     lat    = (o == 3'd4) ? mc : 1;
        longint exp_r;
        int     dones  = 0, errs = 0, done_at = -1, err_at = -1, busy_n = 0;

        cur_sel = sel;
        exp_r = legal ? ref_res(int'(o), am, bm) : (sel ? exp16 : exp8);
        @(negedge clk);
        drive(sel, o, am, bm, 1'b1);
        @(posedge clk);
        #1;
        if (busy_s) busy_n++;
        drive(sel, 3'($urandom), longint'($urandom), longint'($urandom), 1'b1);
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(posedge clk);
            #1;
            if (busy_s) busy_n++;
            if (done_s) begin dones++; done_at = cyc; end
            if (err_s)  begin errs++;  err_at  = cyc; end
            if (cyc == hold) drive(sel, 3'($urandom), longint'($urandom), longint'($urandom), 1'b0);
        end
        drive(sel, 3'd0, 0, 0, 1'b0);
        @(posedge clk);
        #1;
        check("done_count", dones, legal ? 1 : 0);
        if (legal) check("done_latency", done_at, lat);
        check("err_count", errs, illeg ? 1 : 0);
        if (illeg) check("err_latency", err_at, 1);
        check("busy_cycles", busy_n, legal ? lat : 0);
        check("result", longint'(result_s), exp_r);
        if (sel) exp16 = exp_r; else exp8 = exp_r;
    endtask

    initial begin
        int dcount;
        reset_n = 1'b0;
        drive(1'b0, 3'd0, 0, 0, 1'b0);
        drive(1'b1, 3'd0, 0, 0, 1'b0);
        #2;
        check("rst_done", done8, 0);
        check("rst_err", err8, 0);
        check("rst_busy", busy8, 0);
        check("rst_result8", result8, 0);
        check("rst_result16", result16, 0);
        @(negedge clk);
        reset_n = 1'b1;

        cmd(1'b0, 3'd1, 'hFF, 'hFF, 2);
        check("add_ff_ff", result8, 'h01FE);
        cmd(1'b0, 3'd4, 'hFF, 'hFF, 1);
        check("mul_ff_ff", result8, 'hFE01);
        cmd(1'b0, 3'd1, 'h01, 'h02, 3);
        cmd(1'b0, 3'd6, 'h11, 'h22, 2);
        check("illegal_keeps", result8, 'h0003);
        cmd(1'b0, 3'd0, 'h05, 'h05, 2);
        cmd(1'b0, 3'd3, 'hF0, 'h3C, 10);
        check("xor_f0_3c", result8, 'h00CC);

        // reset in the middle of a multiply
        cur_sel = 1'b0;
        @(negedge clk);
        drive(1'b0, 3'd4, 'h0F, 'h0F, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        start8  = 1'b0;
        #1;
        check("rst_mid_busy", busy8, 0);
        check("rst_mid_result", result8, 0);
        check("rst_mid_done", done8, 0);
        @(negedge clk);
        reset_n = 1'b1;
        exp8  = 0;
        exp16 = 0;
        dcount = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (done8) dcount++;
        end
        check("no_done_after_abort", dcount, 0);

        cmd(1'b0, 3'd2, 'hAA, 'h0F, 1);

        for (int i = 0; i < 40; i++)
            cmd(1'b0, 3'($urandom_range(7)), longint'($urandom), longint'($urandom),
                int'($urandom_range(6, 1)));

        cmd(1'b1, 3'd4, 'hFFFF, 'hFFFF, 1);
        check("mul16_ffff", result16, 'hFFFE0001);
        for (int i = 0; i < 15; i++)
            cmd(1'b1, 3'($urandom_range(7)), longint'($urandom), longint'($urandom),
                int'($urandom_range(4, 1)));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
